// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave state type
// for the on-chip SRAM slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    function automatic logic [3:0] byte_enables(
        input logic [2:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        be = 4'b1111;
        if (size == HSIZE_BYTE) be = 4'b0001 << lane;
        if (size == HSIZE_HALF) be = 4'b0011 << lane;
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: per-byte synchronous write,
// asynchronous read. Contents are never reset.
module ahb_sram_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             hclk,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge hclk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: FSM, wait-state counter,
// legality check and byte-enable decode.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 0
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic                      hmastlock_i,
    input  logic [31:0]               hwdata_i,
    input  logic                      hready_i,
    output logic                      hreadyout_o,
    output logic [31:0]               hrdata_o,
    output logic [1:0]                hresp_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam logic [1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    slave_state_e     state_q, state_d;
    slave_state_e     acc_state;
    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic [3:0]       be_q, be_d;

    logic        slave_ready;
    logic        accept;
    logic        illegal;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        unused_ok;

    assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

    // ready is a pure function of state, so accept never loops through outputs
    assign slave_ready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign accept = hsel_i & htrans_i[1] & hready_i & slave_ready;

    always_comb begin
        illegal = 1'b0;
        if (hsize_i > HSIZE_WORD) illegal = 1'b1;
        if (hsize_i == HSIZE_HALF && haddr_i[0]) illegal = 1'b1;
        if (hsize_i == HSIZE_WORD && haddr_i[1:0] != 2'b00) illegal = 1'b1;
        if (64'(haddr_i[AHB_ADDR_WIDTH-1:2]) >= 64'(MEM_DEPTH_WORDS))
            illegal = 1'b1;
    end

    always_comb begin
        acc_state = ST_DATA;
        if (WAIT_STATES > 0) acc_state = ST_WAIT;
        if (illegal) acc_state = ST_ERR1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        be_d        = be_q;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_ERR2) hresp_o = HRESP_ERROR;
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = acc_state;
                    cnt_d   = WAIT_INIT;
                    idx_d   = haddr_i[IDX_W+1:2];
                    write_d = hwrite_i;
                    be_d    = illegal ? 4'b0000
                                      : byte_enables(hsize_i, haddr_i[1:0]);
                end
            end
            ST_WAIT: begin
                hreadyout_o = 1'b0;
                if (cnt_q == 2'd0) state_d = ST_DATA;
                else cnt_d = cnt_q - 2'd1;
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_d     = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            be_q    <= be_d;
        end
    end

    // the data cycle is the only one in which the array is written or read out
    assign mem_we   = (state_q == ST_DATA && write_q) ? be_q : 4'b0000;
    assign hrdata_o = (state_q == ST_DATA && !write_q) ? mem_rdata : 32'd0;

    ahb_sram_array #(
        .DEPTH (MEM_DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .hclk    (hclk),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (hwdata_i),
        .rdata_o (mem_rdata)
    );

endmodule
